// File: rtl/sysid_pkg.sv
// rtl/sysid_pkg.sv - shared types and constants for the system-ID boot checker
package sysid_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_ID,
        WAIT_ID,
        RD_TS,
        WAIT_TS,
        CHECK,
        GAP,
        DONE
    } sysid_chk_state_t;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    localparam int SYSID_ATT_W = 4;
    localparam int SYSID_CNT_W = 8;

    function automatic logic [SYSID_ATT_W-1:0] sysid_sat_inc(input logic [SYSID_ATT_W-1:0] v);
        return (v == '1) ? v : v + SYSID_ATT_W'(1);
    endfunction

endpackage

// File: rtl/sysid_boot_checker_if.sv
// rtl/sysid_boot_checker_if.sv - read bus between the boot checker and the system-ID slave
interface sysid_boot_checker_if;
    logic        sid_address;
    logic        sid_read;
    logic [31:0] sid_readdata;

    modport master (
        output sid_address,
        output sid_read,
        input  sid_readdata
    );

    modport slave (
        input  sid_address,
        input  sid_read,
        output sid_readdata
    );
endinterface

// File: rtl/sysid_delay_cnt.sv
// rtl/sysid_delay_cnt.sv - loadable down-counter with zero flag for read latency and retry gap
module sysid_delay_cnt
    import sysid_pkg::*;
#(
    parameter int W = SYSID_CNT_W
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/sysid_boot_checker.sv
// rtl/sysid_boot_checker.sv - boot-time ID/timestamp checker with bounded retries
// Timestamp read and compare are built only with SYSID_CHECK_TIMESTAMP_EN defined.
module sysid_boot_checker
    import sysid_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID  = 32'd7,
    parameter logic [31:0] EXPECTED_TS  = 32'd1385930693,
    parameter int          READ_LATENCY = 1,
    parameter int          MAX_RETRIES  = 3,
    parameter int          GAP_CYCLES   = 16
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   start,
    sysid_boot_checker_if.master   sid,
    output logic                   done,
    output logic                   pass,
    output logic [31:0]            captured_id,
    output logic [31:0]            captured_ts,
    output logic [SYSID_ATT_W-1:0] attempts
);

    localparam logic [SYSID_CNT_W-1:0] LAT_LOAD =
        (READ_LATENCY > 0) ? SYSID_CNT_W'(READ_LATENCY - 1) : '0;
    localparam logic [SYSID_CNT_W-1:0] GAP_LOAD    = SYSID_CNT_W'(GAP_CYCLES - 1);
    localparam logic [SYSID_ATT_W-1:0] RETRY_LIMIT = SYSID_ATT_W'(MAX_RETRIES);

    sysid_chk_state_t       state;
    logic                   read_q;
    logic                   addr_q;
    logic                   done_q;
    logic                   pass_q;
    logic [31:0]            cap_id_q;
    logic [SYSID_ATT_W-1:0] att_q;
    logic [SYSID_ATT_W-1:0] att_inc;

    logic                   cnt_load;
    logic                   cnt_dec;
    logic                   cnt_zero;
    logic [SYSID_CNT_W-1:0] cnt_value;

    logic                   id_capture;
    logic                   chk_ok;

    // One counter serves both the read-latency wait and the retry gap.
    always_comb begin
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        cnt_value = LAT_LOAD;
        case (state)
            RD_ID, RD_TS: cnt_load = 1'b1;
            CHECK: begin
                cnt_load  = 1'b1;
                cnt_value = GAP_LOAD;
            end
            WAIT_ID, WAIT_TS, GAP: cnt_dec = 1'b1;
            default: ;
        endcase
    end

    sysid_delay_cnt #(
        .W (SYSID_CNT_W)
    ) u_delay_cnt (
        .clock      (clock),
        .reset_n    (reset_n),
        .load       (cnt_load),
        .load_value (cnt_value),
        .dec        (cnt_dec),
        .zero       (cnt_zero)
    );

    assign id_capture = (state == RD_ID) ? (READ_LATENCY == 0)
                                         : ((state == WAIT_ID) && cnt_zero);
    assign att_inc    = sysid_sat_inc(att_q);

`ifdef SYSID_CHECK_TIMESTAMP_EN
    logic [31:0] cap_ts_q;
    logic        ts_capture;

    assign ts_capture  = (state == RD_TS) ? (READ_LATENCY == 0)
                                          : ((state == WAIT_TS) && cnt_zero);
    assign chk_ok      = (cap_id_q == EXPECTED_ID) && (cap_ts_q == EXPECTED_TS);
    assign captured_ts = cap_ts_q;
`else
    logic unused_ts_cfg;

    assign unused_ts_cfg = ^{EXPECTED_TS, SYSID_ADDR_TS};
    assign chk_ok        = (cap_id_q == EXPECTED_ID);
    assign captured_ts   = '0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            read_q   <= 1'b0;
            addr_q   <= SYSID_ADDR_ID;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            cap_id_q <= '0;
            att_q    <= '0;
`ifdef SYSID_CHECK_TIMESTAMP_EN
            cap_ts_q <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    state  <= RD_ID;
                    read_q <= 1'b1;
                    addr_q <= SYSID_ADDR_ID;
                end
                RD_ID, WAIT_ID: begin
                    read_q <= 1'b0;
                    addr_q <= SYSID_ADDR_ID;
                    if (id_capture) begin
                        cap_id_q <= sid.sid_readdata;
`ifdef SYSID_CHECK_TIMESTAMP_EN
                        state  <= RD_TS;
                        read_q <= 1'b1;
                        addr_q <= SYSID_ADDR_TS;
`else
                        state  <= CHECK;
`endif
                    end else begin
                        state <= WAIT_ID;
                    end
                end
`ifdef SYSID_CHECK_TIMESTAMP_EN
                RD_TS, WAIT_TS: begin
                    read_q <= 1'b0;
                    addr_q <= SYSID_ADDR_ID;
                    if (ts_capture) begin
                        cap_ts_q <= sid.sid_readdata;
                        state    <= CHECK;
                    end else begin
                        state <= WAIT_TS;
                    end
                end
`endif
                CHECK: begin
                    att_q <= att_inc;
                    if (chk_ok) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                        pass_q <= 1'b1;
                    end else if (att_inc <= RETRY_LIMIT) begin
                        state <= GAP;
                    end else begin
                        state  <= DONE;
                        done_q <= 1'b1;
                        pass_q <= 1'b0;
                    end
                end
                GAP: begin
                    if (cnt_zero) begin
                        state  <= RD_ID;
                        read_q <= 1'b1;
                        addr_q <= SYSID_ADDR_ID;
                    end
                end
                DONE: begin
                    // A re-run starts from a clean slate, including the captured words.
                    if (start) begin
                        state    <= RD_ID;
                        read_q   <= 1'b1;
                        addr_q   <= SYSID_ADDR_ID;
                        done_q   <= 1'b0;
                        pass_q   <= 1'b0;
                        cap_id_q <= '0;
                        att_q    <= '0;
`ifdef SYSID_CHECK_TIMESTAMP_EN
                        cap_ts_q <= '0;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign sid.sid_read    = read_q;
    assign sid.sid_address = addr_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign captured_id     = cap_id_q;
    assign attempts        = att_q;

endmodule

// File: tb/tb_sysid_boot_checker.sv
// tb/tb_sysid_boot_checker.sv - vector-table and sequence bench for sysid_boot_checker
module tb_sysid_boot_checker;

`ifdef SYSID_CHECK_TIMESTAMP_EN
    localparam bit TS_EN = 1'b1;
`else
    localparam bit TS_EN = 1'b0;
`endif
    localparam int          A       = TS_EN ? 5 : 3;
    localparam int          G       = 16;
    localparam logic [31:0] TS_GOOD = 32'd1385930693;
    localparam logic [31:0] TS_BAD  = 32'd1385930692;
    localparam logic [31:0] ID_BAD  = 32'd9;

    logic        clock   = 1'b0;
    logic        reset_n = 1'b0;
    logic        start   = 1'b0;
    logic        done;
    logic        pass;
    logic [31:0] captured_id;
    logic [31:0] captured_ts;
    logic [3:0]  attempts;

    sysid_boot_checker_if sid ();

    sysid_boot_checker dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .sid         (sid),
        .done        (done),
        .pass        (pass),
        .captured_id (captured_id),
        .captured_ts (captured_ts),
        .attempts    (attempts)
    );

    always #5 clock = ~clock;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic        rd_pend = 1'b0;
    logic [31:0] rd_word = '0;
    int          n_id = 0;
    int          n_ts = 0;
    int          last_id_cyc = -1;
    int          first_ts_cyc = -1;
    int          addr_viol = 0;
    logic [31:0] id_word = 32'd7;
    logic [31:0] ts_word = TS_GOOD;
    int          id_bad = 0;
    int          ts_bad = 0;

    // Slave model: a read seen in cycle k returns its word during cycle k+1 only.
    always @(negedge clock) begin
        if (!reset_n) begin
            rd_pend      = 1'b0;
            n_id         = 0;
            n_ts         = 0;
            last_id_cyc  = -1;
            first_ts_cyc = -1;
        end else begin
            if (sid.sid_read !== 1'b1 && sid.sid_address !== 1'b0) addr_viol++;
            rd_pend = (sid.sid_read === 1'b1);
            if (rd_pend) begin
                if (sid.sid_address == 1'b0) begin
                    n_id++;
                    last_id_cyc = cyc;
                    if (id_bad > 0) begin rd_word = ID_BAD; id_bad--; end
                    else rd_word = id_word;
                end else begin
                    n_ts++;
                    if (first_ts_cyc < 0) first_ts_cyc = cyc;
                    if (ts_bad > 0) begin rd_word = TS_BAD; ts_bad--; end
                    else rd_word = ts_word;
                end
            end
        end
    end

    always @(posedge clock) begin
        #1;
        if (!reset_n) cyc = 0;
        else cyc++;
        sid.sid_readdata = rd_pend ? rd_word : 32'hDEAD_BEEF;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        start   = 1'b0;
        repeat (3) @(posedge clock);
        #2;
    endtask

    task automatic release_reset();
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic wait_done(input int budget, output int ncyc);
        ncyc = -1;
        for (int i = 1; i <= budget; i++) begin
            @(posedge clock);
            #2;
            if (done === 1'b1) begin
                ncyc = i;
                break;
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_sid_read"}, 32'(sid.sid_read), 32'd0);
        chk({tag, "_sid_address"}, 32'(sid.sid_address), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_pass"}, 32'(pass), 32'd0);
        chk({tag, "_captured_id"}, captured_id, 32'd0);
        chk({tag, "_captured_ts"}, captured_ts, 32'd0);
        chk({tag, "_attempts"}, 32'(attempts), 32'd0);
    endtask

    typedef struct {
        logic [31:0] id_word;
        int          id_bad;
        logic [31:0] ts_word;
        int          ts_bad;
        logic        exp_pass;
        int          exp_att;
        logic [31:0] exp_cap_id;
        logic [31:0] exp_cap_ts;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int nc;
        int base_id;

        vecs[0] = '{32'd7, 0, TS_GOOD, 0, 1'b1, 1, 32'd7, TS_EN ? TS_GOOD : 32'd0};
        vecs[1] = '{32'd8, 0, TS_GOOD, 0, 1'b0, 4, 32'd8, TS_EN ? TS_GOOD : 32'd0};
        vecs[2] = '{32'd7, 0, TS_GOOD, 1, 1'b1, TS_EN ? 2 : 1, 32'd7, TS_EN ? TS_GOOD : 32'd0};
        vecs[3] = '{32'd7, 0, TS_GOOD, 99, TS_EN ? 1'b0 : 1'b1, TS_EN ? 4 : 1, 32'd7,
                    TS_EN ? TS_BAD : 32'd0};
        vecs[4] = '{32'd7, 2, TS_GOOD, 0, 1'b1, 3, 32'd7, TS_EN ? TS_GOOD : 32'd0};

        apply_reset();
        check_reset_outputs("reset");

        for (int v = 0; v < 5; v++) begin
            apply_reset();
            id_word = vecs[v].id_word;
            id_bad  = vecs[v].id_bad;
            ts_word = vecs[v].ts_word;
            ts_bad  = vecs[v].ts_bad;
            release_reset();
            wait_done(400, nc);
            chk($sformatf("v%0d_done_cycle", v), nc,
                1 + vecs[v].exp_att * A + (vecs[v].exp_att - 1) * G);
            chk($sformatf("v%0d_pass", v), 32'(pass), 32'(vecs[v].exp_pass));
            chk($sformatf("v%0d_attempts", v), 32'(attempts), vecs[v].exp_att);
            chk($sformatf("v%0d_captured_id", v), captured_id, vecs[v].exp_cap_id);
            chk($sformatf("v%0d_captured_ts", v), captured_ts, vecs[v].exp_cap_ts);
            chk($sformatf("v%0d_id_reads", v), n_id, vecs[v].exp_att);
            chk($sformatf("v%0d_ts_reads", v), n_ts, TS_EN ? vecs[v].exp_att : 0);
            chk($sformatf("v%0d_last_id_cycle", v), last_id_cyc,
                1 + (vecs[v].exp_att - 1) * (A + G));
            chk($sformatf("v%0d_first_ts_cycle", v), first_ts_cyc, TS_EN ? 3 : -1);
        end

        // Reset pulsed in the middle of the last wait state of an attempt.
        apply_reset();
        id_word = 32'd7;
        id_bad  = 0;
        ts_word = TS_GOOD;
        ts_bad  = 0;
        release_reset();
        repeat (TS_EN ? 4 : 2) @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midrun_reset");
        repeat (2) @(posedge clock);
        release_reset();
        wait_done(400, nc);
        chk("rerun_done_cycle", nc, 1 + A);
        chk("rerun_pass", 32'(pass), 32'd1);
        chk("rerun_attempts", 32'(attempts), 32'd1);

        // Re-run via start with a now-wrong ID; further start pulses must be ignored.
        id_word = 32'd5;
        base_id = n_id;
        start   = 1'b1;
        @(posedge clock);
        #2;
        start = 1'b0;
        chk("start_done_low", 32'(done), 32'd0);
        chk("start_pass_low", 32'(pass), 32'd0);
        chk("start_attempts_clr", 32'(attempts), 32'd0);
        chk("start_captured_id_clr", captured_id, 32'd0);
        chk("start_sid_read", 32'(sid.sid_read), 32'd1);
        chk("start_sid_address", 32'(sid.sid_address), 32'd0);
        nc = -1;
        for (int i = 1; i <= 400; i++) begin
            @(posedge clock);
            #2;
            start = (i == 10 || i == 30 || i == 45);
            if (done === 1'b1) begin
                nc = i;
                break;
            end
        end
        start = 1'b0;
        chk("restart_done_cycle", nc, 4 * A + 4 * G - G);
        chk("restart_pass", 32'(pass), 32'd0);
        chk("restart_attempts", 32'(attempts), 32'd4);
        chk("restart_captured_id", captured_id, 32'd5);
        chk("restart_id_reads", n_id - base_id, 32'd4);

        repeat (5) @(posedge clock);
        #2;
        chk("done_sticky", 32'(done), 32'd1);
        chk("address_idle_zero", addr_viol, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
